// File: rtl/phase_pkg.sv
// Shared types and phase numbering for the LEGv8 phase sequencer.
package phase_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STALL,
    HALT,
    PAUSE
  } state_t;

  localparam int PH_PC        = 0;
  localparam int PH_FETCH     = 1;
  localparam int PH_DECODE    = 2;
  localparam int PH_EXECUTE   = 3;
  localparam int PH_MEM_READ  = 4;
  localparam int PH_MEM_WRITE = 5;
  localparam int PH_REG_WRITE = 6;

endpackage

// File: rtl/stall_watchdog.sv
// Consecutive-stall counter; expired flags the cycle the limit is reached.
module stall_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = en && (cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// One-hot phase sequencer for the nonpipelined LEGv8 datapath.
// Optional single-step pause: PHASE_SEQUENCER_SINGLE_STEP_EN.
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int NUM_PHASES    = 7,
  parameter int STALL_PHASE   = PH_EXECUTE,
  parameter int MAX_INSTR     = 100,
  parameter int STALL_TIMEOUT = 64,
  parameter int COUNT_W       = 16,
  localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  halt_req,
`ifdef PHASE_SEQUENCER_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [PW-1:0]         phase_idx,
  output logic                  instr_done,
  output logic [COUNT_W-1:0]    instr_count,
  output logic                  running,
  output logic                  halted,
  output logic                  error
);

  localparam logic [PW-1:0] LAST = PW'(NUM_PHASES - 1);
  localparam logic [PW-1:0] SPH  = PW'(STALL_PHASE);
  localparam logic [PW-1:0] SNX  = PW'(STALL_PHASE + 1);
  localparam logic [NUM_PHASES-1:0] ONE = NUM_PHASES'(1);
  localparam logic [COUNT_W:0] MAX_L = (COUNT_W + 1)'(MAX_INSTR);

  state_t state;
  logic   halt_pend;
  logic   wd_en;
  logic   wd_clr;
  logic   wd_expired;

  logic [PW-1:0]      nxt_idx;
  logic [COUNT_W:0]   cnt_inc;
  logic [COUNT_W-1:0] cnt_sat;
  logic               at_last;
  logic               limit_hit;
  logic               halt_now;

  assign nxt_idx   = phase_idx + PW'(1);
  assign cnt_inc   = {1'b0, instr_count} + (COUNT_W + 1)'(1);
  assign cnt_sat   = (&instr_count) ? instr_count
                                    : cnt_inc[COUNT_W-1:0];
  assign at_last   = (phase_idx == LAST);
  assign limit_hit = (MAX_INSTR != 0) && (cnt_inc == MAX_L);
  assign halt_now  = limit_hit || halt_req || halt_pend;

  assign wd_en  = (state == STALL) && stall;
  assign wd_clr = !wd_en;

  stall_watchdog #(
    .TIMEOUT (STALL_TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      phase_en    <= '0;
      phase_idx   <= '0;
      instr_done  <= 1'b0;
      instr_count <= '0;
      running     <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
      halt_pend   <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      unique case (state)
        IDLE, HALT: begin
          if (start) begin
            state       <= RUN;
            phase_idx   <= '0;
            phase_en    <= ONE;
            instr_count <= '0;
            running     <= 1'b1;
            halted      <= 1'b0;
            error       <= 1'b0;
            halt_pend   <= 1'b0;
          end
        end
        RUN: begin
          if (halt_req) halt_pend <= 1'b1;
          if (at_last) begin
            instr_count <= cnt_sat;
            phase_idx   <= '0;
            if (halt_now) begin
              state    <= HALT;
              phase_en <= '0;
              running  <= 1'b0;
              halted   <= 1'b1;
            end else begin
`ifdef PHASE_SEQUENCER_SINGLE_STEP_EN
              state    <= PAUSE;
              phase_en <= '0;
              running  <= 1'b0;
`else
              phase_en <= ONE;
`endif
            end
          end else if (phase_idx == SPH && stall) begin
            state <= STALL;
          end else begin
            phase_idx  <= nxt_idx;
            phase_en   <= ONE << nxt_idx;
            instr_done <= (nxt_idx == LAST);
          end
        end
        STALL: begin
          if (halt_req) halt_pend <= 1'b1;
          if (!stall) begin
            state      <= RUN;
            phase_idx  <= SNX;
            phase_en   <= ONE << SNX;
            instr_done <= (SNX == LAST);
          end else if (wd_expired) begin
            state     <= HALT;
            phase_idx <= '0;
            phase_en  <= '0;
            running   <= 1'b0;
            halted    <= 1'b1;
            error     <= 1'b1;
          end
        end
`ifdef PHASE_SEQUENCER_SINGLE_STEP_EN
        PAUSE: begin
          if (step) begin
            state     <= RUN;
            phase_idx <= '0;
            phase_en  <= ONE;
            running   <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench: default unit (limit 100, watchdog 64) and a
// second unit with limit 3 and watchdog 8.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic s0 = 1'b0, st0 = 1'b0, hr0 = 1'b0;
  logic s1 = 1'b0, st1 = 1'b0, hr1 = 1'b0;
  logic step = 1'b0;

  logic [6:0]  pe0, pe1;
  logic [2:0]  pi0, pi1;
  logic        done0, done1;
  logic [15:0] cnt0, cnt1;
  logic        run0, run1, hlt0, hlt1, err0, err1;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  phase_sequencer u0 (
    .clk         (clk),
    .reset       (reset),
    .start       (s0),
    .stall       (st0),
    .halt_req    (hr0),
`ifdef PHASE_SEQUENCER_SINGLE_STEP_EN
    .step        (step),
`endif
    .phase_en    (pe0),
    .phase_idx   (pi0),
    .instr_done  (done0),
    .instr_count (cnt0),
    .running     (run0),
    .halted      (hlt0),
    .error       (err0)
  );

  phase_sequencer #(
    .MAX_INSTR     (3),
    .STALL_TIMEOUT (8)
  ) u1 (
    .clk         (clk),
    .reset       (reset),
    .start       (s1),
    .stall       (st1),
    .halt_req    (hr1),
`ifdef PHASE_SEQUENCER_SINGLE_STEP_EN
    .step        (step),
`endif
    .phase_en    (pe1),
    .phase_idx   (pi1),
    .instr_done  (done1),
    .instr_count (cnt1),
    .running     (run1),
    .halted      (hlt1),
    .error       (err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cyc;
    int dones;
    int guard;

    s0 = 1'b1;
    tick();
    tick();
    chk("rst_pe", 32'(pe0), 32'h0);
    chk("rst_idx", 32'(pi0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_cnt", 32'(cnt0), 32'h0);
    chk("rst_run", 32'(run0), 32'h0);
    chk("rst_hlt", 32'(hlt0), 32'h0);
    chk("rst_err", 32'(err0), 32'h0);

    reset = 1'b1;
    tick();
    s0 = 1'b0;
    chk("first_pe", 32'(pe0), 32'h1);
    chk("first_run", 32'(run0), 32'h1);
    chk("first_idx", 32'(pi0), 32'h0);
    for (int i = 1; i < 7; i++) begin
      tick();
      chk("seq_idx", 32'(pi0), 32'(i));
      chk("seq_pe", 32'(pe0), 32'(1) << i);
      chk("seq_done", 32'(done0), (i == 6) ? 32'h1 : 32'h0);
    end
    tick();
    chk("wrap_cnt", 32'(cnt0), 32'h1);
    chk("wrap_pe", 32'(pe0), 32'h1);
    chk("wrap_done", 32'(done0), 32'h0);

`ifndef PHASE_SEQUENCER_SINGLE_STEP_EN
    tick();
    tick();
    hr0 = 1'b1;
    tick();
    hr0 = 1'b0;
    chk("hreq_no_trunc", 32'(pi0), 32'h3);
    tick();
    tick();
    tick();
    chk("hreq_done", 32'(done0), 32'h1);
    tick();
    chk("hreq_hlt", 32'(hlt0), 32'h1);
    chk("hreq_pe", 32'(pe0), 32'h0);
    chk("hreq_cnt", 32'(cnt0), 32'h2);
    chk("hreq_run", 32'(run0), 32'h0);
    chk("hreq_err", 32'(err0), 32'h0);
    tick();
    chk("hreq_hold", 32'(hlt0), 32'h1);

    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    chk("restart_pe", 32'(pe0), 32'h1);
    chk("restart_cnt", 32'(cnt0), 32'h0);
    chk("restart_hlt", 32'(hlt0), 32'h0);

    tick();
    tick();
    tick();
    st0 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("stall_pe", 32'(pe0), 32'h8);
      tick();
    end
    st0 = 1'b0;
    chk("stall_last_pe", 32'(pe0), 32'h8);
    chk("stall_idx", 32'(pi0), 32'h3);
    chk("stall_run", 32'(run0), 32'h1);
    tick();
    chk("post_stall_pe", 32'(pe0), 32'h10);
    tick();
    tick();
    chk("stall_instr_done", 32'(done0), 32'h1);
    tick();
    chk("stall_instr_cnt", 32'(cnt0), 32'h1);

    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    chk("stall_ignored", 32'(pi0), 32'h1);
    tick();
    tick();
    tick();
    chk("pre_rst_idx", 32'(pi0), 32'h4);
`else
    tick();
    tick();
    tick();
    tick();
    chk("pre_rst_idx", 32'(pi0), 32'h4);
`endif

    #3;
    reset = 1'b0;
    #1;
    chk("arst_pe", 32'(pe0), 32'h0);
    chk("arst_idx", 32'(pi0), 32'h0);
    chk("arst_cnt", 32'(cnt0), 32'h0);
    chk("arst_run", 32'(run0), 32'h0);
    chk("arst_done", 32'(done0), 32'h0);
    #2;
    reset = 1'b1;
    tick();

`ifdef PHASE_SEQUENCER_SINGLE_STEP_EN
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("step_done", 32'(done0), 32'h1);
    tick();
    chk("pause_pe", 32'(pe0), 32'h0);
    chk("pause_run", 32'(run0), 32'h0);
    chk("pause_cnt", 32'(cnt0), 32'h1);
    tick();
    tick();
    chk("pause_hold", 32'(pe0), 32'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_pe", 32'(pe0), 32'h1);
    chk("step_run", 32'(run0), 32'h1);
`else
    s1 = 1'b1;
    tick();
    s1 = 1'b0;
    cyc = 0;
    dones = 0;
    guard = 0;
    while (!hlt1 && guard < 40) begin
      if (run1) cyc++;
      if (done1) dones++;
      tick();
      guard++;
    end
    chk("lim_cycles", 32'(cyc), 32'd21);
    chk("lim_dones", 32'(dones), 32'd3);
    chk("lim_hlt", 32'(hlt1), 32'h1);
    chk("lim_pe", 32'(pe1), 32'h0);
    chk("lim_cnt", 32'(cnt1), 32'h3);
    chk("lim_err", 32'(err1), 32'h0);
`endif

    s1 = 1'b1;
    tick();
    s1 = 1'b0;
    tick();
    tick();
    tick();
    st1 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("wd_pe", 32'(pe1), 32'h8);
      tick();
    end
    chk("wd_hlt", 32'(hlt1), 32'h1);
    chk("wd_err", 32'(err1), 32'h1);
    chk("wd_pe_off", 32'(pe1), 32'h0);
    st1 = 1'b0;
    s1 = 1'b1;
    tick();
    s1 = 1'b0;
    chk("wd_clr_err", 32'(err1), 32'h0);
    chk("wd_clr_cnt", 32'(cnt1), 32'h0);
    chk("wd_restart_pe", 32'(pe1), 32'h1);

`ifndef PHASE_SEQUENCER_SINGLE_STEP_EN
    for (int i = 0; i < 20; i++) tick();
    chk("both_idx", 32'(pi1), 32'h6);
    chk("both_done", 32'(done1), 32'h1);
    hr1 = 1'b1;
    tick();
    hr1 = 1'b0;
    chk("both_hlt", 32'(hlt1), 32'h1);
    chk("both_err", 32'(err1), 32'h0);
    chk("both_cnt", 32'(cnt1), 32'h3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Single-clock phase sequencer for the nonpipelined LEGv8 datapath; replaces the chain of delayed clocks with one-hot phase enables on a single `clk`.
- Steps each instruction through NUM_PHASES phases: PC update, fetch read, decode read, execute, memory read, memory write, register write.
- Holds the execute phase while the multiplier stalls.
- Counts retired instructions, halts on limit/request/stall timeout.

Parameters:
- NUM_PHASES, 7, phases per instruction (index 0 = PC update, NUM_PHASES-1 = register write); minimum 2.
- STALL_PHASE, 3, phase index that honours `stall`; must be < NUM_PHASES-1.
- MAX_INSTR, 100, instruction limit before automatic halt; 0 = unlimited.
- STALL_TIMEOUT, 64, maximum consecutive stalled cycles before error halt; 0 = watchdog disabled.
- COUNT_W, 16, width of instruction counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin/restart execution (level sampled per clk).
- stall  input  1  execute-unit busy (multiplier running).
- halt_req  input  1  request halt at next instruction boundary.
- phase_en  output  NUM_PHASES  registered one-hot phase enable.
- phase_idx  output  $clog2(NUM_PHASES)  current phase index.
- instr_done  output  1  one-cycle pulse when the last phase completes.
- instr_count  output  COUNT_W  retired instructions.
- running  output  1  high in RUN or STALL.
- halted  output  1  high in HALT.
- error  output  1  stall watchdog expired; sticky until reset or restart.

Behaviour:
- Reset (reset=0, async): state IDLE; phase_en=0, phase_idx=0, instr_done=0, instr_count=0, running=0, halted=0, error=0, stall counter=0.
- States: IDLE, RUN, STALL, HALT.
- IDLE: start=1 -> RUN next cycle with phase_idx=0, phase_en=1<<0. Otherwise hold.
- RUN: phase_idx advances by 1 each clk.
  - phase_en always equals 1<<phase_idx.
  - At phase_idx=NUM_PHASES-1, instr_done pulses for that cycle; on the next edge instr_count increments (saturating at 2^COUNT_W-1).
  - At that same boundary: if MAX_INSTR!=0 and count+1==MAX_INSTR, or halt_req is high, go to HALT. Otherwise wrap to phase 0.
- Stall: in RUN at phase_idx==STALL_PHASE with stall=1 -> STALL.
  - phase_en[STALL_PHASE] stays asserted every cycle so execute keeps iterating; phase_idx holds; stall counter increments.
  - stall=0 -> RUN at STALL_PHASE+1; stall counter clears.
  - Stall counter reaching STALL_TIMEOUT (non-zero) -> HALT with error=1.
- stall is ignored in every other phase.
- halt_req is latched (pending flag) whenever it is seen in RUN/STALL. It acts only at the instruction boundary and never truncates an instruction.
- HALT: phase_en=0, halted=1. start=1 -> RUN at phase 0; instr_count, error and the pending flag are cleared.
- Simultaneous limit reached and halt_req at the boundary: HALT, error=0.
- start while RUN/STALL: ignored.
- Reset mid-instruction: immediate return to reset values; no partial instr_done.

Optional Feature:
- Macro: PHASE_SEQUENCER_SINGLE_STEP_EN.
- Enabled: adds input `step` (1 bit). After each instruction boundary the sequencer enters a PAUSE state (phase_en=0, running=0). A `step`=1 cycle resumes at phase 0. Halt conditions are evaluated before PAUSE, so halt has priority.
- Disabled: no `step` port and no PAUSE state; wrap is immediate.

Decomposition:
- Shared package phase_pkg:
  - state enum (IDLE, RUN, STALL, HALT, PAUSE);
  - phase index constants PH_PC=0, PH_FETCH=1, PH_DECODE=2, PH_EXECUTE=3, PH_MEM_READ=4, PH_MEM_WRITE=5, PH_REG_WRITE=6.
- Sub-module stall_watchdog: counter with clear, enable, and expiry flag. Parameter TIMEOUT, disabled when 0.

Test Plan:
- Reset with start=1, then release -> all outputs 0 during reset. First RUN cycle phase_en=7'b0000001; instr_done on 7th cycle; instr_count=1 after 7 cycles.
- MAX_INSTR=3, start pulse, no stall -> exactly 21 RUN cycles, 3 instr_done pulses, then halted=1, phase_en=0, instr_count=3.
- stall=1 for 10 cycles on entering phase 3 -> phase_en=7'b0001000 held 11 cycles total. Phase 4 follows; instruction takes 17 cycles.
- STALL_TIMEOUT=8, stall held high -> HALT after 8 stalled cycles, error=1. Then start -> error=0, instr_count=0, phase_en=1.
- halt_req pulsed at phase 2 of instruction 1 -> phases 3..6 complete, instr_count=1, halted=1. Limit and halt_req at the same boundary -> error=0.
- reset asserted at phase 4 -> outputs 0 asynchronously, before the next clk. With SINGLE_STEP_EN: no progress past the boundary until the step pulse.
